// File: rtl/i2c_pkg.sv
// Shared I2C definitions: target FSM states, ACK/NACK levels, input sync latency.
package i2c_pkg;

  localparam int unsigned SYNC_LAT = 3;
  localparam int unsigned CNT_W    = 4;

  localparam logic I2C_ACK  = 1'b0;
  localparam logic I2C_NACK = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_PTR,
    ST_PTR_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_tgt_state_t;

endpackage

// File: rtl/i2c_bus_sync.sv
// Two-FF synchronizers on SCL/SDA plus a history stage for edge, START and STOP detection.
module i2c_bus_sync (
  input  logic aclk,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_rise,
  output logic scl_fall,
  output logic start_det,
  output logic stop_det,
  output logic sda_s
);

  logic scl_meta_q, scl_s_q, scl_h_q;
  logic sda_meta_q, sda_s_q, sda_h_q;

  // Chains free-run through reset so they always mirror the bus and never fake an edge.
  always_ff @(posedge aclk) begin
    scl_meta_q <= scl_i;
    scl_s_q    <= scl_meta_q;
    scl_h_q    <= scl_s_q;
    sda_meta_q <= sda_i;
    sda_s_q    <= sda_meta_q;
    sda_h_q    <= sda_s_q;
  end

  assign scl_rise  = scl_s_q & ~scl_h_q;
  assign scl_fall  = ~scl_s_q & scl_h_q;
  assign start_det = scl_s_q & scl_h_q & sda_h_q & ~sda_s_q;
  assign stop_det  = scl_s_q & scl_h_q & ~sda_h_q & sda_s_q;
  assign sda_s     = sda_s_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target exposing a byte register file with an auto-incrementing pointer.
module i2c_target_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  TARGET_ADDR = 7'h03,
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [7:0]  RESET_FILL  = 8'h00
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        scl_i,
  input  logic                        sda_i,
  output logic                        sda_pull,
  output logic                        wr_strobe,
  output logic [$clog2(NUM_REGS)-1:0] wr_idx,
  output logic [7:0]                  wr_data,
  output logic                        busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REGS);

  logic scl_rise, scl_fall, start_det, stop_det, sda_s;

  i2c_bus_sync u_sync (
    .aclk      (aclk),
    .scl_i     (scl_i),
    .sda_i     (sda_i),
    .scl_rise  (scl_rise),
    .scl_fall  (scl_fall),
    .start_det (start_det),
    .stop_det  (stop_det),
    .sda_s     (sda_s)
  );

  i2c_tgt_state_t   state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q, bitcnt_d;
  logic [7:0]       shift_q, shift_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             rw_q, rw_d;
  logic             sda_pull_q, sda_pull_d;
  logic             busy_q, busy_d;
  logic             wr_strobe_q, wr_strobe_d;
  logic [PTR_W-1:0] wr_idx_q, wr_idx_d;
  logic [7:0]       wr_data_q, wr_data_d;
  logic [7:0]       regs_q [NUM_REGS];

  logic             reg_we_c;
  logic [7:0]       byte_c, rd_byte_c, nxt_byte_c;
  logic [PTR_W-1:0] ptr_inc_c;

  assign byte_c     = {shift_q[6:0], sda_s};
  assign ptr_inc_c  = ptr_q + PTR_W'(1);
  assign rd_byte_c  = regs_q[ptr_q];
  assign nxt_byte_c = regs_q[ptr_inc_c];

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q     <= ST_IDLE;
      bitcnt_q    <= '0;
      shift_q     <= '0;
      ptr_q       <= '0;
      rw_q        <= 1'b0;
      sda_pull_q  <= 1'b0;
      busy_q      <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_idx_q    <= '0;
      wr_data_q   <= '0;
    end else begin
      state_q     <= state_d;
      bitcnt_q    <= bitcnt_d;
      shift_q     <= shift_d;
      ptr_q       <= ptr_d;
      rw_q        <= rw_d;
      sda_pull_q  <= sda_pull_d;
      busy_q      <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_idx_q    <= wr_idx_d;
      wr_data_q   <= wr_data_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_FILL;
    end else if (reg_we_c) begin
      regs_q[ptr_q] <= byte_c;
    end
  end

  // ACK states use bitcnt as a phase: 0 wait fall, 1 wait ACK rise, 2 wait release fall.
  always_comb begin
    state_d     = state_q;
    bitcnt_d    = bitcnt_q;
    shift_d     = shift_q;
    ptr_d       = ptr_q;
    rw_d        = rw_q;
    sda_pull_d  = sda_pull_q;
    busy_d      = busy_q;
    wr_strobe_d = 1'b0;
    wr_idx_d    = wr_idx_q;
    wr_data_d   = wr_data_q;
    reg_we_c    = 1'b0;

    if (start_det) begin
      state_d    = ST_ADDR;
      bitcnt_d   = '0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
    end else if (stop_det) begin
      state_d    = ST_IDLE;
      bitcnt_d   = '0;
      sda_pull_d = 1'b0;
      busy_d     = 1'b0;
    end else begin
      case (state_q)
        ST_ADDR, ST_PTR, ST_WDATA: begin
          if (scl_rise) begin
            shift_d  = byte_c;
            bitcnt_d = bitcnt_q + CNT_W'(1);
            if (bitcnt_q == CNT_W'(7)) begin
              bitcnt_d = '0;
              if (state_q == ST_ADDR) begin
                if (byte_c[7:1] == TARGET_ADDR && byte_c[7:1] != 7'h00) begin
                  state_d = ST_ADDR_ACK;
                  rw_d    = byte_c[0];
                  busy_d  = 1'b1;
                end else begin
                  state_d = ST_IGNORE;
                  busy_d  = 1'b0;
                end
              end else if (state_q == ST_PTR) begin
                ptr_d   = byte_c[PTR_W-1:0];
                state_d = ST_PTR_ACK;
              end else begin
                reg_we_c    = 1'b1;
                wr_strobe_d = 1'b1;
                wr_idx_d    = ptr_q;
                wr_data_d   = byte_c;
                ptr_d       = ptr_inc_c;
                state_d     = ST_WDATA_ACK;
              end
            end
          end
        end
        ST_ADDR_ACK, ST_PTR_ACK, ST_WDATA_ACK: begin
          if (scl_fall && bitcnt_q == CNT_W'(0)) begin
            sda_pull_d = ~I2C_ACK;
            bitcnt_d   = CNT_W'(1);
          end else if (scl_rise && bitcnt_q == CNT_W'(1)) begin
            bitcnt_d = CNT_W'(2);
          end else if (scl_fall && bitcnt_q == CNT_W'(2)) begin
            sda_pull_d = 1'b0;
            bitcnt_d   = '0;
            if (state_q == ST_ADDR_ACK && rw_q) begin
              state_d    = ST_RDATA;
              shift_d    = rd_byte_c;
              sda_pull_d = ~rd_byte_c[7];
            end else if (state_q == ST_ADDR_ACK) begin
              state_d = ST_PTR;
            end else begin
              state_d = ST_WDATA;
            end
          end
        end
        ST_RDATA: begin
          if (scl_rise) begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end else if (scl_fall && bitcnt_q != CNT_W'(0)) begin
            if (bitcnt_q == CNT_W'(8)) begin
              sda_pull_d = 1'b0;
              bitcnt_d   = '0;
              state_d    = ST_RDATA_ACK;
            end else begin
              shift_d    = {shift_q[6:0], 1'b0};
              sda_pull_d = ~shift_q[6];
            end
          end
        end
        ST_RDATA_ACK: begin
          if (scl_rise && bitcnt_q == CNT_W'(0)) begin
            if (sda_s == I2C_NACK) begin
              state_d = ST_IGNORE;
              busy_d  = 1'b0;
            end else begin
              bitcnt_d = CNT_W'(1);
            end
          end else if (scl_fall && bitcnt_q == CNT_W'(1)) begin
            ptr_d      = ptr_inc_c;
            shift_d    = nxt_byte_c;
            sda_pull_d = ~nxt_byte_c[7];
            bitcnt_d   = '0;
            state_d    = ST_RDATA;
          end
        end
        default: ;
      endcase
    end
  end

  assign sda_pull  = sda_pull_q;
  assign wr_strobe = wr_strobe_q;
  assign wr_idx    = wr_idx_q;
  assign wr_data   = wr_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Bench for i2c_target_regs: bit-banged I2C master against a register-file/pointer model.
module tb_i2c_target_regs;
  import i2c_pkg::*;

  localparam int unsigned NREGS = 16;
  localparam int unsigned PW    = 4;
  localparam logic [6:0]  TADDR = 7'h03;
  localparam logic [7:0]  FILL  = 8'h00;
  localparam logic [7:0]  ADDR_W = {TADDR, 1'b0};
  localparam logic [7:0]  ADDR_R = {TADDR, 1'b1};
  localparam int          Q = 4;

  logic          aclk = 1'b0;
  logic          areset, scl_m, sda_m, sda_line;
  logic          sda_pull, wr_strobe, busy;
  logic [PW-1:0] wr_idx;
  logic [7:0]    wr_data;

  assign sda_line = sda_m & ~sda_pull;

  i2c_target_regs #(.TARGET_ADDR(TADDR), .NUM_REGS(NREGS), .RESET_FILL(FILL)) dut (
    .aclk      (aclk),
    .areset    (areset),
    .scl_i     (scl_m),
    .sda_i     (sda_line),
    .sda_pull  (sda_pull),
    .wr_strobe (wr_strobe),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
    .busy      (busy)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  logic [7:0] model_regs [NREGS];
  int         model_ptr;
  logic [7:0] data_buf [4];

  typedef struct packed { logic [PW-1:0] idx; logic [7:0] data; } wr_ev_t;
  wr_ev_t obs_q[$];
  wr_ev_t exp_q[$];
  bit     pull_seen, busy_seen;

  always @(negedge aclk) begin
    if (wr_strobe) obs_q.push_back({wr_idx, wr_data});
    if (sda_pull)  pull_seen = 1'b1;
    if (busy)      busy_seen = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge aclk);
  endtask

  task automatic bus_bit(input logic b, output logic s);
    scl_m = 1'b0; tick(Q);
    sda_m = b;    tick(Q);
    scl_m = 1'b1; tick(2*Q - 1);
    s = sda_line; tick(1);
  endtask

  task automatic start_c();
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b1; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    sda_m = 1'b0; tick(2*Q);
  endtask

  task automatic stop_c();
    scl_m = 1'b0; tick(Q);
    sda_m = 1'b0; tick(Q);
    scl_m = 1'b1; tick(2*Q);
    sda_m = 1'b1; tick(2*Q);
  endtask

  task automatic send_chk(input logic [7:0] b, input logic exp_ack, input string tag);
    logic s, ack;
    for (int i = 7; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, ack);
    check(tag, 32'(ack), 32'(exp_ack));
  endtask

  task automatic recv_byte(output logic [7:0] b, input logic mack);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, s);
      b[i] = s;
    end
    bus_bit(mack, s);
  endtask

  task automatic check_strobes(input string tag);
    check({tag, "_nstrobe"}, 32'(obs_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < obs_q.size(); k++)
      check({tag, "_strobe"}, 32'(obs_q[k]), 32'(exp_q[k]));
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic do_write(input int p, input int n, input string tag);
    start_c();
    send_chk(ADDR_W, I2C_ACK, {tag, "_ack_addr"});
    check({tag, "_busy_on"}, 32'(busy), 32'd1);
    send_chk(8'(p), I2C_ACK, {tag, "_ack_ptr"});
    for (int k = 0; k < n; k++) begin
      send_chk(data_buf[k], I2C_ACK, {tag, "_ack_data"});
      model_regs[(p + k) % NREGS] = data_buf[k];
      exp_q.push_back({PW'((p + k) % NREGS), data_buf[k]});
    end
    model_ptr = (p + n) % NREGS;
    stop_c();
    tick(SYNC_LAT + 1);
    check({tag, "_busy_off"}, 32'(busy), 32'd0);
    check_strobes(tag);
  endtask

  // p < 0 reads from the retained pointer; sr selects repeated START vs STOP+START
  task automatic do_read(input int p, input int n, input bit sr, input string tag);
    logic [7:0] b;
    int base;
    if (p >= 0) begin
      start_c();
      send_chk(ADDR_W, I2C_ACK, {tag, "_ack_addr"});
      send_chk(8'(p), I2C_ACK, {tag, "_ack_ptr"});
      if (!sr) stop_c();
      base = p;
    end else begin
      base = model_ptr;
    end
    start_c();
    send_chk(ADDR_R, I2C_ACK, {tag, "_ack_raddr"});
    for (int k = 0; k < n; k++) begin
      recv_byte(b, (k == n - 1) ? I2C_NACK : I2C_ACK);
      check({tag, "_rdata"}, 32'(b), 32'(model_regs[(base + k) % NREGS]));
    end
    model_ptr = (base + n - 1) % NREGS;
    check({tag, "_pull_after_nack"}, 32'(sda_pull), 32'd0);
    check({tag, "_busy_after_nack"}, 32'(busy), 32'd0);
    stop_c();
    check_strobes(tag);
  endtask

  initial begin
    logic s, a;
    logic [7:0] b;

    areset = 1'b1; scl_m = 1'b1; sda_m = 1'b1;
    tick(5);
    check("rst_sda_pull", 32'(sda_pull), 32'd0);
    check("rst_wr_strobe", 32'(wr_strobe), 32'd0);
    check("rst_wr_idx", 32'(wr_idx), 32'd0);
    check("rst_wr_data", 32'(wr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    areset = 1'b0;
    tick(SYNC_LAT + 2);
    for (int i = 0; i < NREGS; i++) model_regs[i] = FILL;
    model_ptr = 0;
    obs_q.delete();

    data_buf[0] = 8'hA5; data_buf[1] = 8'h5A;
    do_write(2, 2, "wr_basic");
    do_read(2, 2, 1'b1, "rd_sr");

    pull_seen = 1'b0; busy_seen = 1'b0;
    start_c();
    send_chk(8'h10, I2C_NACK, "wrong_addr_ack");
    send_chk(8'h00, I2C_NACK, "wrong_addr_data");
    stop_c();
    check("wrong_addr_pull", 32'(pull_seen), 32'd0);
    check("wrong_addr_busy", 32'(busy_seen), 32'd0);
    check_strobes("wrong_addr");

    data_buf[0] = 8'h11; data_buf[1] = 8'h22;
    do_write(15, 2, "wrap_wr");
    do_read(15, 2, 1'b1, "wrap_rd");

    start_c();
    send_chk(ADDR_W, I2C_ACK, "rstmid_ack_addr");
    send_chk(8'h05, I2C_ACK, "rstmid_ack_ptr");
    b = 8'hC3;
    for (int i = 7; i >= 5; i--) bus_bit(b[i], s);
    scl_m = 1'b0; tick(Q);
    sda_m = b[4]; tick(Q);
    scl_m = 1'b1; tick(2);
    areset = 1'b1; tick(1);
    areset = 1'b0;
    check("rstmid_pull", 32'(sda_pull), 32'd0);
    check("rstmid_busy", 32'(busy), 32'd0);
    tick(2*Q - 3);
    for (int i = 3; i >= 0; i--) bus_bit(b[i], s);
    bus_bit(1'b1, a);
    check("rstmid_no_ack", 32'(a), 32'(I2C_NACK));
    stop_c();
    check_strobes("rstmid");
    for (int i = 0; i < NREGS; i++) model_regs[i] = FILL;
    model_ptr = 0;
    do_read(-1, 1, 1'b0, "rstmid_rd0");
    do_read(15, 2, 1'b0, "rstmid_rdfill");
    data_buf[0] = 8'h3C;
    do_write(5, 1, "rstmid_wr");
    do_read(5, 1, 1'b1, "rstmid_rd");

    data_buf[0] = 8'h77;
    do_write(9, 1, "stopmid_pre");
    start_c();
    send_chk(ADDR_W, I2C_ACK, "stopmid_ack_addr");
    send_chk(8'h09, I2C_ACK, "stopmid_ack_ptr");
    for (int i = 0; i < 3; i++) bus_bit(1'b0, s);
    stop_c();
    check_strobes("stopmid");
    model_ptr = 9;
    do_read(-1, 1, 1'b0, "stopmid_rd");

    for (int r = 0; r < 10; r++) begin
      int kind, p, n;
      kind = int'($urandom_range(0, 2));
      p    = int'($urandom_range(0, NREGS - 1));
      n    = int'($urandom_range(1, 3));
      if (kind == 0) begin
        for (int k = 0; k < n; k++) data_buf[k] = 8'($urandom);
        do_write(p, n, "rnd_wr");
      end else if (kind == 1) begin
        do_read(p, n, 1'($urandom), "rnd_rd");
      end else begin
        do_read(-1, n, 1'b0, "rnd_rdcur");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
